// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle signed WIDTHxWIDTH multiply / divide unit feeding the HI/LO
//   result registers. One operand bit is processed per clock on unsigned
//   magnitudes; signs are applied in a single fix-up cycle at the end.
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high; returns the unit to IDLE
//     start        request an operation (sampled only in IDLE)
//     op           0 = multiply, 1 = divide (sampled with start)
//     a, b         signed operands (sampled with start)
//     busy         high from the accepting edge until done drops
//     done         one-cycle pulse, results valid
//     wr_flag      identical to done; write enable for HI/LO registers
//     result_lo    product low half or quotient
//     result_hi    product high half or remainder
//     div_by_zero  set with done for a divide by zero, cleared on next start
//
//   Timing: start sampled at edge E0, done high in the cycle after
//   E(WIDTH+2); a new start can be accepted at E(WIDTH+3).
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr_flag,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement negate of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        neg_w = (~x) + ONE_W;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        neg_2w = (~x) + ONE_2W;
    endfunction

    // Unsigned magnitude of a signed value; the most negative value maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1]) begin
            mag_w = neg_w(x);
        end else begin
            mag_w = x;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   op_q, op_d;
    logic                   sa_q, sa_d;          // sign of a
    logic                   sb_q, sb_d;          // sign of b
    logic                   bz_q, bz_d;          // divisor was zero
    logic [WIDTH-1:0]       opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     acc_q, acc_d;        // {upper partial, multiplier/dividend}
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    // Multiply step: conditionally add the multiplicand to the upper half,
    // then shift the whole accumulator right (carry enters the top bit).
    logic [WIDTH:0]         mul_sum_s;
    logic [2*WIDTH-1:0]     mul_next_s;

    // Divide step: shift remainder left taking the next dividend bit, trial
    // subtract the divisor, restore when the trial goes negative.
    logic [WIDTH:0]         div_shift_s;
    logic [WIDTH:0]         div_trial_s;
    logic [2*WIDTH-1:0]     div_next_s;

    // Sign fix-up values used in the FIX state.
    logic                   res_neg_s;
    logic [2*WIDTH-1:0]     prod_fix_s;
    logic [WIDTH-1:0]       quo_fix_s;
    logic [WIDTH-1:0]       rem_fix_s;

    assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next_s  = acc_q[0] ? {mul_sum_s, acc_q[WIDTH-1:1]}
                                  : {1'b0, acc_q[2*WIDTH-1:1]};

    assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial_s = div_shift_s - {1'b0, opnd_q};
    assign div_next_s  = div_trial_s[WIDTH]
                       ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                       : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign res_neg_s   = sa_q ^ sb_q;
    assign prod_fix_s  = res_neg_s ? neg_2w(acc_q) : acc_q;
    // A zero divisor leaves the quotient magnitude all ones; it is reported
    // as all ones regardless of operand signs.
    assign quo_fix_s   = bz_q ? {WIDTH{1'b1}}
                              : (res_neg_s ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
    assign rem_fix_s   = sa_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    bz_d    = (b == {WIDTH{1'b0}});
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    if (op) begin
                        opnd_d = mag_w(b);
                        acc_d  = {{WIDTH{1'b0}}, mag_w(a)};
                    end else begin
                        opnd_d = mag_w(a);
                        acc_d  = {{WIDTH{1'b0}}, mag_w(b)};
                    end
                end else begin
                    // busy stays high through the done cycle and drops here.
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (op_q) begin
                    acc_d = div_next_s;
                end else begin
                    acc_d = mul_next_s;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_FIX: begin
                if (op_q) begin
                    lo_d = quo_fix_s;
                    hi_d = rem_fix_s;
                end else begin
                    lo_d = prod_fix_s[WIDTH-1:0];
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                dbz_d   = op_q & bz_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_flag     = done_q;
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W   = 16;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic          wr_flag;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic          div_by_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .wr_flag     (wr_flag),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    // Reference: plain signed integer arithmetic. Returns {dbz, hi, lo}.
    function automatic logic [32:0] ref_model(input logic op_i, input logic [15:0] a_i,
                                              input logic [15:0] b_i);
        int sa, sb, q, r, p;
        logic [31:0] pv;
        logic [15:0] qv, rv;
        sa = int'($signed(a_i));
        sb = int'($signed(b_i));
        if (!op_i) begin
            p  = sa * sb;
            pv = p;
            return {1'b0, pv};
        end else if (sb == 0) begin
            return {1'b1, a_i, 16'hFFFF};
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            qv = q[15:0];
            rv = r[15:0];
            return {1'b0, rv, qv};
        end
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h8000;
            1:       v = 16'h7FFF;
            2:       v = 16'hFFFF;
            3:       v = 16'h0001;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // Issues one operation and watches 40 cycles. Optional start pulses are
    // driven at cycles p1/p2 (0 = none). side_ok tracks wr_flag==done and
    // busy high exactly up to and including the done cycle.
    task automatic do_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                         input int p1, input int p2,
                         output int lat, output int pulses,
                         output logic [15:0] lo, output logic [15:0] hi, output logic dbz,
                         output logic side_ok, output logic [31:0] held);
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; pulses = 0; side_ok = 1'b1; lo = '0; hi = '0; dbz = 1'b0;
        if (busy !== 1'b1) side_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (wr_flag !== done) side_ok = 1'b0;
            if (busy !== ((lat < 0) ? 1'b1 : 1'b0)) side_ok = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; lo = result_lo; hi = result_hi; dbz = div_by_zero;
                end
            end
            if (k == p1 || k == p2) begin
                start = 1'b1; op = ~op_i; a = 16'($urandom); b = 16'($urandom);
            end
        end
        held = {result_hi, result_lo};
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, wr_flag, div_by_zero} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, want 0000", {busy, done, wr_flag, div_by_zero});
        end
        tests_run++;
        if ({result_hi, result_lo} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_results: got %h, want 00000000", {result_hi, result_lo});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith(input logic op_i, input int n_rand);
        logic [15:0] ta[6], tb[6];
        logic [15:0] av, bv, lo, hi;
        logic [32:0] exp;
        logic        dbz, side_ok;
        logic [31:0] held;
        int          lat, pulses;
        if (!op_i) begin
            ta = '{16'd3, 16'h8000, 16'h7FFF, 16'd0, 16'hFFFF, 16'h8000};
            tb = '{16'hFFFB, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h7FFF};
        end else begin
            ta = '{16'hFFF9, 16'd7, 16'd9, 16'h7FFF, 16'h8000, 16'd5};
            tb = '{16'd2, 16'hFFFE, 16'd3, 16'h8000, 16'h7FFF, 16'd7};
        end
        for (int i = 0; i < 6 + n_rand; i++) begin
            if (i < 6) begin
                av = ta[i]; bv = tb[i];
            end else begin
                av = pick_operand(); bv = pick_operand();
                if (op_i && $urandom_range(0, 9) == 0) bv = 16'h0;
            end
            exp = ref_model(op_i, av, bv);
            do_op(op_i, av, bv, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
            tests_run++;
            if (lat !== LAT) begin
                tests_failed++;
                $display("FAIL latency op=%0b a=%h b=%h: got %0d, want %0d", op_i, av, bv, lat, LAT);
            end
            tests_run++;
            if ({dbz, hi, lo} !== exp) begin
                tests_failed++;
                $display("FAIL result op=%0b a=%h b=%h: got dbz=%b hi=%h lo=%h, want dbz=%b hi=%h lo=%h",
                         op_i, av, bv, dbz, hi, lo, exp[32], exp[31:16], exp[15:0]);
            end
            tests_run++;
            if (pulses !== 1 || side_ok !== 1'b1 || held !== exp[31:0]) begin
                tests_failed++;
                $display("FAIL handshake op=%0b a=%h b=%h: got pulses=%0d side_ok=%b held=%h, want 1 1 %h",
                         op_i, av, bv, pulses, side_ok, held, exp[31:0]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [15:0] lo, hi;
        logic        dbz, side_ok;
        logic [31:0] held;
        int          lat, pulses;
        do_op(1'b1, 16'd100, 16'd0, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
        tests_run++;
        if ({dbz, hi, lo} !== {1'b1, 16'h0064, 16'hFFFF} || lat !== LAT || pulses !== 1) begin
            tests_failed++;
            $display("FAIL dbz_pos: got dbz=%b hi=%h lo=%h lat=%0d pulses=%0d, want 1 0064 ffff %0d 1",
                     dbz, hi, lo, lat, pulses, LAT);
        end
        tests_run++;
        if (div_by_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbz_hold: got %b, want 1", div_by_zero);
        end
        do_op(1'b1, 16'hFFFB, 16'd0, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
        tests_run++;
        if ({dbz, hi, lo} !== {1'b1, 16'hFFFB, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL dbz_neg: got dbz=%b hi=%h lo=%h, want 1 fffb ffff", dbz, hi, lo);
        end
        do_op(1'b1, 16'd9, 16'd3, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
        tests_run++;
        if ({dbz, hi, lo} !== {1'b0, 16'h0000, 16'h0003} || div_by_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL dbz_clear: got dbz=%b hi=%h lo=%h flag=%b, want 0 0000 0003 0",
                     dbz, hi, lo, div_by_zero);
        end
    endtask

    task automatic test_overflow_busy_start();
        logic [15:0] lo, hi;
        logic        dbz, side_ok;
        logic [31:0] held;
        int          lat, pulses;
        do_op(1'b1, 16'h8000, 16'hFFFF, 3, 10, lat, pulses, lo, hi, dbz, side_ok, held);
        tests_run++;
        if ({dbz, hi, lo} !== {1'b0, 16'h0000, 16'h8000}) begin
            tests_failed++;
            $display("FAIL overflow_result: got dbz=%b hi=%h lo=%h, want 0 0000 8000", dbz, hi, lo);
        end
        tests_run++;
        if (pulses !== 1 || lat !== LAT || side_ok !== 1'b1 || held !== 32'h00008000) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got pulses=%0d lat=%0d side_ok=%b held=%h, want 1 %0d 1 00008000",
                     pulses, lat, side_ok, held, LAT);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] lo, hi;
        logic        dbz, side_ok;
        logic [31:0] held;
        int          lat, pulses;
        do_op(1'b0, 16'd3, 16'hFFFB, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
        @(negedge clk);
        op = 1'b0; a = 16'd1234; b = 16'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if ({busy, done, wr_flag, div_by_zero} !== 4'b0000 || {result_hi, result_lo} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: got flags=%b res=%h, want 0000 00000000",
                     {busy, done, wr_flag, div_by_zero}, {result_hi, result_lo});
        end
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || wr_flag !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL reset_discard: got %0d done cycles, want 0", pulses);
        end
        do_op(1'b0, 16'd6, 16'd7, 0, 0, lat, pulses, lo, hi, dbz, side_ok, held);
        tests_run++;
        if ({hi, lo} !== 32'h0000002A || lat !== LAT || pulses !== 1) begin
            tests_failed++;
            $display("FAIL after_reset_mul: got hi=%h lo=%h lat=%0d pulses=%0d, want 0000 002a %0d 1",
                     hi, lo, lat, pulses, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        logic [32:0] e1, e2;
        int          lat1, lat2;
        e1 = ref_model(1'b1, 16'hFFF9, 16'd2);
        e2 = ref_model(1'b0, 16'hFFF9, 16'h1234);
        @(negedge clk);
        op = 1'b1; a = 16'hFFF9; b = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat1 = -1; r1 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat1 = k; r1 = {result_hi, result_lo};
                op = 1'b0; a = 16'hFFF9; b = 16'h1234; start = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (lat1 !== LAT || {busy, done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_accept: got lat=%0d busy=%b done=%b, want %0d 1 0", lat1, busy, done, LAT);
        end
        lat2 = -1; r2 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat2 = k; r2 = {result_hi, result_lo};
                break;
            end
        end
        tests_run++;
        if (r1 !== e1[31:0] || r2 !== e2[31:0] || lat2 !== LAT) begin
            tests_failed++;
            $display("FAIL b2b_results: got r1=%h r2=%h lat2=%0d, want %h %h %0d",
                     r1, r2, lat2, e1[31:0], e2[31:0], LAT);
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_arith(1'b0, 20);
        test_arith(1'b1, 20);
        test_div_by_zero();
        test_overflow_busy_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
